// File: rtl/dmem_responder.sv
// Memory-side responder for two cores' load/store ports: round-robin grant onto one
// single-port RAM, with level (four-phase) request/valid handshakes per port.
module dmem_responder #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req0,
    input  logic                 rd_req1,
    input  logic [ADDR_SIZE-1:0] rd_adrs0,
    input  logic [ADDR_SIZE-1:0] rd_adrs1,
    input  logic                 wr_req0,
    input  logic                 wr_req1,
    input  logic [ADDR_SIZE-1:0] wr_adrs0,
    input  logic [ADDR_SIZE-1:0] wr_adrs1,
    input  logic [DATA_SIZE-1:0] wr_data0,
    input  logic [DATA_SIZE-1:0] wr_data1,
    output logic                 rd_valid0,
    output logic                 rd_valid1,
    output logic [DATA_SIZE-1:0] rd_data0,
    output logic [DATA_SIZE-1:0] rd_data1,
    output logic                 wr_valid0,
    output logic                 wr_valid1,
    output logic                 busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t                 state;
    logic                   rr_ptr;
    logic                   port_p0;
    logic                   wr_p0;
    logic [ADDR_SIZE-1:0]   adrs_p0;
    logic [DATA_SIZE-1:0]   data_p0;

    logic [DATA_SIZE-1:0]   mem [0:(1<<ADDR_SIZE)-1];

    logic                   elig0;
    logic                   elig1;
    logic                   gnt_port;
    logic                   gnt_wr;
    logic [ADDR_SIZE-1:0]   gnt_adrs;
    logic [DATA_SIZE-1:0]   gnt_data;

    // Eligibility looks only at registered valids, so a port whose valid is
    // clearing this cycle cannot be granted until the next one.
    always_comb begin
        elig0    = (rd_req0 | wr_req0) & ~rd_valid0 & ~wr_valid0;
        elig1    = (rd_req1 | wr_req1) & ~rd_valid1 & ~wr_valid1;
        gnt_port = (elig0 & elig1) ? rr_ptr : elig1;
        gnt_wr   = gnt_port ? wr_req1 : wr_req0;
        gnt_adrs = '0;
        gnt_data = gnt_port ? wr_data1 : wr_data0;
        if (gnt_port)
            gnt_adrs = gnt_wr ? wr_adrs1 : rd_adrs1;
        else
            gnt_adrs = gnt_wr ? wr_adrs0 : rd_adrs0;
    end

    // Grant stage (IDLE) -> execute stage (EXEC)
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            busy      <= 1'b0;
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
            wr_valid0 <= 1'b0;
            wr_valid1 <= 1'b0;
            rd_data0  <= '0;
            rd_data1  <= '0;
        end else begin
            if (rd_valid0 && !rd_req0) rd_valid0 <= 1'b0;
            if (rd_valid1 && !rd_req1) rd_valid1 <= 1'b0;
            if (wr_valid0 && !wr_req0) wr_valid0 <= 1'b0;
            if (wr_valid1 && !wr_req1) wr_valid1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        port_p0 <= gnt_port;
                        wr_p0   <= gnt_wr;
                        adrs_p0 <= gnt_adrs;
                        data_p0 <= gnt_data;
                        rr_ptr  <= ~gnt_port;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (wr_p0) begin
                        if (port_p0) wr_valid1 <= 1'b1;
                        else         wr_valid0 <= 1'b1;
                    end else if (port_p0) begin
                        rd_valid1 <= 1'b1;
                        rd_data1  <= mem[adrs_p0];
                    end else begin
                        rd_valid0 <= 1'b1;
                        rd_data0  <= mem[adrs_p0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset landing on the EXEC edge drops the pending store.
    always_ff @(posedge clk) begin
        if (!reset && state == EXEC && wr_p0)
            mem[adrs_p0] <= data_p0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: handshake timing, round-robin order,
// hazards, held requests and reset during an access.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req0, rd_req1, wr_req0, wr_req1;
    logic [10:0] rd_adrs0, rd_adrs1, wr_adrs0, wr_adrs1;
    logic [31:0] wr_data0, wr_data1;
    logic        rd_valid0, rd_valid1, wr_valid0, wr_valid1, busy;
    logic [31:0] rd_data0, rd_data1;

    int total = 0;
    int bad   = 0;
    int busy_cnt;
    logic all_high;

    dmem_responder #(.DATA_SIZE(32), .ADDR_SIZE(11)) dut (
        .clk(clk), .reset(reset),
        .rd_req0(rd_req0), .rd_req1(rd_req1),
        .rd_adrs0(rd_adrs0), .rd_adrs1(rd_adrs1),
        .wr_req0(wr_req0), .wr_req1(wr_req1),
        .wr_adrs0(wr_adrs0), .wr_adrs1(wr_adrs1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .wr_valid0(wr_valid0), .wr_valid1(wr_valid1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        rd_req0 = 0; rd_req1 = 0; wr_req0 = 0; wr_req1 = 0;
        rd_adrs0 = 0; rd_adrs1 = 0; wr_adrs0 = 0; wr_adrs1 = 0;
        wr_data0 = 0; wr_data1 = 0;
        do_reset();

        chk("rst_rv0", {31'b0, rd_valid0}, 32'd0);
        chk("rst_rv1", {31'b0, rd_valid1}, 32'd0);
        chk("rst_wv0", {31'b0, wr_valid0}, 32'd0);
        chk("rst_wv1", {31'b0, wr_valid1}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rd0", rd_data0, 32'd0);
        chk("rst_rd1", rd_data1, 32'd0);

        // Single store then load on port 0
        wr_req0 = 1; wr_adrs0 = 11'h010; wr_data0 = 32'hDEADBEEF;
        tick();
        chk("st_busy", {31'b0, busy}, 32'd1);
        chk("st_wv0_early", {31'b0, wr_valid0}, 32'd0);
        tick();
        chk("st_wv0", {31'b0, wr_valid0}, 32'd1);
        chk("st_busy_off", {31'b0, busy}, 32'd0);
        tick(); tick();
        chk("st_wv0_hold", {31'b0, wr_valid0}, 32'd1);
        wr_req0 = 0;
        tick();
        chk("st_wv0_clr", {31'b0, wr_valid0}, 32'd0);
        rd_req0 = 1; rd_adrs0 = 11'h010;
        tick(); tick();
        chk("ld_rv0", {31'b0, rd_valid0}, 32'd1);
        chk("ld_rd0", rd_data0, 32'hDEADBEEF);
        rd_req0 = 0;
        tick();
        chk("ld_rv0_clr", {31'b0, rd_valid0}, 32'd0);

        // Contention after reset: port 0 first
        do_reset();
        rd_req0 = 1; rd_req1 = 1; rd_adrs0 = 11'h010; rd_adrs1 = 11'h010;
        tick(); tick();
        chk("c1_rv0", {31'b0, rd_valid0}, 32'd1);
        chk("c1_rv1_wait", {31'b0, rd_valid1}, 32'd0);
        tick(); tick();
        chk("c1_rv1", {31'b0, rd_valid1}, 32'd1);
        chk("c1_rd1", rd_data1, 32'hDEADBEEF);
        rd_req0 = 0; rd_req1 = 0;
        tick();

        // One port-0 access so the pointer favours port 1 next
        rd_req0 = 1;
        tick(); tick();
        chk("solo_rv0", {31'b0, rd_valid0}, 32'd1);
        rd_req0 = 0;
        tick();

        // Repeat simultaneous requests: port 1 first
        rd_req0 = 1; rd_req1 = 1;
        tick(); tick();
        chk("c2_rv1", {31'b0, rd_valid1}, 32'd1);
        chk("c2_rv0_wait", {31'b0, rd_valid0}, 32'd0);
        tick(); tick();
        chk("c2_rv0", {31'b0, rd_valid0}, 32'd1);
        rd_req0 = 0; rd_req1 = 0;
        tick();

        // Cross-port ordering at top address: store on port 1 wins, load sees it
        wr_req1 = 1; wr_adrs1 = 11'h7FF; wr_data1 = 32'h12345678;
        rd_req0 = 1; rd_adrs0 = 11'h7FF;
        tick(); tick();
        chk("ord_wv1", {31'b0, wr_valid1}, 32'd1);
        chk("ord_rv0_wait", {31'b0, rd_valid0}, 32'd0);
        tick(); tick();
        chk("ord_rv0", {31'b0, rd_valid0}, 32'd1);
        chk("ord_rd0", rd_data0, 32'h12345678);
        wr_req1 = 0; rd_req0 = 0;
        tick();

        // Held request: one access, valid held throughout
        rd_req0 = 1; rd_adrs0 = 11'h010;
        busy_cnt = 0;
        all_high = 1'b1;
        tick();
        busy_cnt += busy;
        tick();
        busy_cnt += busy;
        chk("hold_rv0", {31'b0, rd_valid0}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            busy_cnt += busy;
            all_high &= rd_valid0;
        end
        chk("hold_busy_cnt", busy_cnt, 32'd1);
        chk("hold_all_high", {31'b0, all_high}, 32'd1);
        rd_req0 = 0;
        tick();
        chk("hold_rv0_clr", {31'b0, rd_valid0}, 32'd0);

        // Same port, both ops: store first, load after store handshake ends
        wr_req0 = 1; wr_adrs0 = 11'h020; wr_data0 = 32'hA5A5A5A5;
        rd_req0 = 1; rd_adrs0 = 11'h020;
        tick(); tick();
        chk("both_wv0", {31'b0, wr_valid0}, 32'd1);
        chk("both_rv0_wait", {31'b0, rd_valid0}, 32'd0);
        tick(); tick();
        chk("both_rv0_held_off", {31'b0, rd_valid0}, 32'd0);
        chk("both_idle", {31'b0, busy}, 32'd0);
        wr_req0 = 0;
        tick();
        chk("both_wv0_clr", {31'b0, wr_valid0}, 32'd0);
        chk("both_no_grant", {31'b0, busy}, 32'd0);
        tick();
        chk("both_ld_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("both_rv0", {31'b0, rd_valid0}, 32'd1);
        chk("both_rd0", rd_data0, 32'hA5A5A5A5);
        rd_req0 = 0;
        tick();

        // Reset mid-EXEC: store must not commit
        wr_req0 = 1; wr_adrs0 = 11'h030; wr_data0 = 32'h0;
        tick(); tick();
        wr_req0 = 0;
        tick();
        wr_req0 = 1; wr_data0 = 32'hFFFFFFFF;
        tick();
        chk("rx_busy", {31'b0, busy}, 32'd1);
        reset = 1; wr_req0 = 0;
        tick();
        reset = 0;
        chk("rx_busy0", {31'b0, busy}, 32'd0);
        chk("rx_wv0", {31'b0, wr_valid0}, 32'd0);
        chk("rx_rd0", rd_data0, 32'd0);
        chk("rx_rd1", rd_data1, 32'd0);
        rd_req0 = 1; rd_adrs0 = 11'h030;
        tick(); tick();
        chk("rx_ld_rv0", {31'b0, rd_valid0}, 32'd1);
        chk("rx_ld_rd0", rd_data0, 32'h0);
        rd_req0 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
